// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types and constants for the vending transaction path
package vending_pkg;

    localparam int CREDITO_W = 4;
    localparam logic [CREDITO_W-1:0] UNIDADE_25 = 4'd1;

    typedef enum logic [2:0] {
        IDLE,
        VERIFICA,
        LIBERA,
        TROCO,
        ZERA
    } estado_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SALDO   = 2'd1,
        ERR_ESTOQUE = 2'd2
    } erro_t;

endpackage

// File: rtl/controle_venda_gerador_troco.sv
// rtl/controle_venda_gerador_troco.sv - change coin pulse generator (coin down-counter plus gap counter)
module gerador_troco
    import vending_pkg::*;
#(
    parameter int CHANGE_GAP = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CREDITO_W-1:0] count,
    output logic                 troco_moeda,
    output logic                 done
);

    localparam logic [7:0] GAP_LAST = 8'(CHANGE_GAP - 1);

    logic [CREDITO_W-1:0] restante;
    logic [7:0]           gap_cnt;

    // The first coin goes out on the same edge that loads the count,
    // so restante holds the coins still owed after the current pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            troco_moeda <= 1'b0;
            restante    <= '0;
            gap_cnt     <= '0;
        end else if (load) begin
            troco_moeda <= (count != '0);
            restante    <= (count != '0) ? count - UNIDADE_25 : '0;
            gap_cnt     <= '0;
        end else if (restante != '0) begin
            if (gap_cnt == GAP_LAST) begin
                troco_moeda <= 1'b1;
                restante    <= restante - UNIDADE_25;
                gap_cnt     <= '0;
            end else begin
                troco_moeda <= 1'b0;
                gap_cnt     <= gap_cnt + 8'd1;
            end
        end else begin
            troco_moeda <= 1'b0;
        end
    end

    assign done = troco_moeda && (restante == '0);

endmodule

// File: rtl/controle_venda.sv
// rtl/controle_venda.sv - vending transaction controller: stock/price check, release, change, credit clear
module controle_venda
    import vending_pkg::*;
#(
    parameter logic [3:0] PRECO_0         = 4'd6,
    parameter logic [3:0] PRECO_1         = 4'd8,
    parameter logic [3:0] PRECO_2         = 4'd10,
    parameter logic [3:0] PRECO_3         = 4'd12,
    parameter int         DISPENSE_CYCLES = 4,
    parameter int         CHANGE_GAP      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CREDITO_W-1:0] credito,
    input  logic [1:0]           produto,
    input  logic                 confirmar,
    input  logic                 cancelar,
    input  logic [3:0]           estoque_vazio,
    output logic                 liberar_produto,
    output logic [1:0]           produto_liberado,
    output logic                 troco_moeda,
    output logic                 zerar_credito,
    output logic                 ocupado,
    output logic [1:0]           erro
);

    localparam logic [7:0] DISP_LAST = 8'(DISPENSE_CYCLES - 1);

    estado_t              estado;
    erro_t                erro_r;
    logic [CREDITO_W-1:0] credito_l;
    logic [CREDITO_W-1:0] troco_l;
    logic [1:0]           produto_l;
    logic [3:0]           estoque_l;
    logic [7:0]           disp_cnt;
    logic [CREDITO_W-1:0] preco;
    logic                 carga;
    logic [CREDITO_W-1:0] carga_valor;
    logic                 troco_done;

    always_comb begin
        case (produto_l)
            2'd0:    preco = PRECO_0;
            2'd1:    preco = PRECO_1;
            2'd2:    preco = PRECO_2;
            default: preco = PRECO_3;
        endcase
    end

    // Load the change generator on the edge that enters TROCO so the first coin
    // appears in the first TROCO cycle.
    always_comb begin
        carga       = 1'b0;
        carga_valor = troco_l;
        if (estado == IDLE && cancelar && credito != '0) begin
            carga       = 1'b1;
            carga_valor = credito;
        end else if (estado == LIBERA && disp_cnt == DISP_LAST && troco_l != '0) begin
            carga = 1'b1;
        end
    end

    gerador_troco #(
        .CHANGE_GAP(CHANGE_GAP)
    ) u_gerador_troco (
        .clk        (clk),
        .reset      (reset),
        .load       (carga),
        .count      (carga_valor),
        .troco_moeda(troco_moeda),
        .done       (troco_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado           <= IDLE;
            erro_r           <= ERR_NONE;
            credito_l        <= '0;
            troco_l          <= '0;
            produto_l        <= '0;
            estoque_l        <= '0;
            disp_cnt         <= '0;
            liberar_produto  <= 1'b0;
            produto_liberado <= '0;
            zerar_credito    <= 1'b0;
            ocupado          <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (cancelar) begin
                        erro_r <= ERR_NONE;
                        if (credito != '0) begin
                            troco_l <= credito;
                            estado  <= TROCO;
                            ocupado <= 1'b1;
                        end
                    end else if (confirmar) begin
                        credito_l <= credito;
                        produto_l <= produto;
                        estoque_l <= estoque_vazio;
                        erro_r    <= ERR_NONE;
                        estado    <= VERIFICA;
                        ocupado   <= 1'b1;
                    end
                end
                VERIFICA: begin
                    if (estoque_l[produto_l]) begin
                        erro_r  <= ERR_ESTOQUE;
                        estado  <= IDLE;
                        ocupado <= 1'b0;
                    end else if (credito_l < preco) begin
                        erro_r  <= ERR_SALDO;
                        estado  <= IDLE;
                        ocupado <= 1'b0;
                    end else begin
                        troco_l          <= credito_l - preco;
                        disp_cnt         <= '0;
                        liberar_produto  <= 1'b1;
                        produto_liberado <= produto_l;
                        estado           <= LIBERA;
                    end
                end
                LIBERA: begin
                    if (disp_cnt == DISP_LAST) begin
                        liberar_produto  <= 1'b0;
                        produto_liberado <= '0;
                        if (troco_l != '0) begin
                            estado <= TROCO;
                        end else begin
                            estado        <= ZERA;
                            zerar_credito <= 1'b1;
                        end
                    end else begin
                        disp_cnt <= disp_cnt + 8'd1;
                    end
                end
                TROCO: begin
                    if (troco_done) begin
                        estado        <= ZERA;
                        zerar_credito <= 1'b1;
                    end
                end
                ZERA: begin
                    zerar_credito <= 1'b0;
                    troco_l       <= '0;
                    ocupado       <= 1'b0;
                    estado        <= IDLE;
                end
                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign erro = erro_r;

endmodule

// File: tb/tb_controle_venda.sv
// tb/tb_controle_venda.sv - table-driven self-checking bench for controle_venda
module tb_controle_venda;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] credito;
    logic [1:0] produto;
    logic       confirmar;
    logic       cancelar;
    logic [3:0] estoque_vazio;
    logic       liberar_produto;
    logic [1:0] produto_liberado;
    logic       troco_moeda;
    logic       zerar_credito;
    logic       ocupado;
    logic [1:0] erro;

    int total = 0;
    int bad   = 0;

    controle_venda dut (
        .clk             (clk),
        .reset           (reset),
        .credito         (credito),
        .produto         (produto),
        .confirmar       (confirmar),
        .cancelar        (cancelar),
        .estoque_vazio   (estoque_vazio),
        .liberar_produto (liberar_produto),
        .produto_liberado(produto_liberado),
        .troco_moeda     (troco_moeda),
        .zerar_credito   (zerar_credito),
        .ocupado         (ocupado),
        .erro            (erro)
    );

    always #5 clk = ~clk;

    // poke_kind: 0 none, 1 confirmar pulse, 2 credito change, 3 reset pulse
    typedef struct {
        logic       conf;
        logic       canc;
        logic [3:0] cred;
        logic [1:0] prod;
        logic [3:0] est;
        int         poke_cyc;
        int         poke_kind;
        logic [3:0] poke_val;
        int         exp_erro;
        int         exp_lib;
        int         exp_pulses;
        int         exp_zera;
    } vec_t;

    vec_t tab[12];

    function automatic vec_t mk(logic conf, logic canc, logic [3:0] cred, logic [1:0] prod,
                                logic [3:0] est, int pc, int pk, logic [3:0] pv,
                                int e_erro, int e_lib, int e_pul, int e_zer);
        vec_t v;
        v.conf = conf; v.canc = canc; v.cred = cred; v.prod = prod; v.est = est;
        v.poke_cyc = pc; v.poke_kind = pk; v.poke_val = pv;
        v.exp_erro = e_erro; v.exp_lib = e_lib; v.exp_pulses = e_pul; v.exp_zera = e_zer;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lib_n = 0, first_lib = -1, pul_n = 0, first_pul = -1, last_pul = -1;
        int gap_bad = 0, zer_n = 0, zer_cyc = -1, prod_bad = 0;
        int erro_c2 = -1, busy_c1 = -1, rst_outs = -1;
        int exp_busy, exp_first_pul, exp_zer_cyc;

        credito = v.cred; produto = v.prod; estoque_vazio = v.est;
        confirmar = v.conf; cancelar = v.canc;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                confirmar = 1'b0;
                cancelar  = 1'b0;
                busy_c1   = int'(ocupado);
            end
            if (k == 2) erro_c2 = int'(erro);
            if (liberar_produto) begin
                lib_n++;
                if (first_lib < 0) first_lib = k;
                if (produto_liberado != v.prod) prod_bad++;
            end
            if (troco_moeda) begin
                if (last_pul >= 0 && k - last_pul != 2) gap_bad++;
                if (first_pul < 0) first_pul = k;
                last_pul = k;
                pul_n++;
            end
            if (zerar_credito) begin
                zer_n++;
                zer_cyc = k;
            end
            if (k == v.poke_cyc + 1) begin
                if (v.poke_kind == 1) confirmar = 1'b0;
                if (v.poke_kind == 3) begin
                    rst_outs = int'({liberar_produto, produto_liberado, troco_moeda,
                                     zerar_credito, ocupado, erro});
                    reset = 1'b0;
                end
            end
            if (k == v.poke_cyc) begin
                case (v.poke_kind)
                    1:       confirmar = 1'b1;
                    2:       credito = v.poke_val;
                    3:       reset = 1'b1;
                    default: ;
                endcase
            end
        end

        exp_busy      = ((v.canc && v.cred != 4'd0) || (v.conf && !v.canc)) ? 1 : 0;
        exp_first_pul = (v.exp_lib > 0) ? 2 + v.exp_lib : 1;
        exp_zer_cyc   = (v.exp_pulses > 0) ? exp_first_pul + 2 * (v.exp_pulses - 1) + 1
                                           : 2 + v.exp_lib;

        chk($sformatf("v%0d ocupado_c1", idx), busy_c1, exp_busy);
        chk($sformatf("v%0d liberar_cycles", idx), lib_n, v.exp_lib);
        chk($sformatf("v%0d troco_pulses", idx), pul_n, v.exp_pulses);
        chk($sformatf("v%0d zerar_count", idx), zer_n, v.exp_zera);
        chk($sformatf("v%0d erro_end", idx), int'(erro), v.exp_erro);
        chk($sformatf("v%0d ocupado_end", idx), int'(ocupado), 0);
        if (v.exp_lib > 0) begin
            chk($sformatf("v%0d liberar_start", idx), first_lib, 2);
            chk($sformatf("v%0d produto_liberado_bad", idx), prod_bad, 0);
        end
        if (v.exp_pulses > 1) chk($sformatf("v%0d troco_gap_bad", idx), gap_bad, 0);
        if (v.exp_pulses > 0 && v.poke_kind != 3)
            chk($sformatf("v%0d troco_first", idx), first_pul, exp_first_pul);
        if (v.exp_zera > 0) chk($sformatf("v%0d zerar_cycle", idx), zer_cyc, exp_zer_cyc);
        if (v.conf && !v.canc) chk($sformatf("v%0d erro_c2", idx), erro_c2, v.exp_erro);
        if (v.poke_kind == 3) chk($sformatf("v%0d outputs_after_reset", idx), rst_outs, 0);
    endtask

    initial begin
        tab[0]  = mk(1, 0, 4'd10, 2'd0, 4'b0000, 0, 0, 4'd0,  0, 4, 4, 1);
        tab[1]  = mk(1, 0, 4'd8,  2'd1, 4'b0000, 0, 0, 4'd0,  0, 4, 0, 1);
        tab[2]  = mk(1, 0, 4'd5,  2'd3, 4'b0000, 0, 0, 4'd0,  1, 0, 0, 0);
        tab[3]  = mk(0, 1, 4'd5,  2'd3, 4'b0000, 0, 0, 4'd0,  0, 0, 5, 1);
        tab[4]  = mk(1, 0, 4'd15, 2'd2, 4'b0100, 0, 0, 4'd0,  2, 0, 0, 0);
        tab[5]  = mk(0, 1, 4'd0,  2'd0, 4'b0000, 0, 0, 4'd0,  0, 0, 0, 0);
        tab[6]  = mk(1, 1, 4'd6,  2'd0, 4'b0000, 0, 0, 4'd0,  0, 0, 6, 1);
        tab[7]  = mk(1, 0, 4'd10, 2'd0, 4'b0000, 3, 1, 4'd0,  0, 4, 4, 1);
        tab[8]  = mk(1, 0, 4'd15, 2'd3, 4'b0000, 7, 2, 4'd1,  0, 4, 3, 1);
        tab[9]  = mk(0, 1, 4'd6,  2'd0, 4'b0000, 2, 2, 4'd15, 0, 0, 6, 1);
        tab[10] = mk(0, 1, 4'd6,  2'd0, 4'b0000, 4, 3, 4'd0,  0, 0, 2, 0);
        tab[11] = mk(1, 0, 4'd3,  2'd0, 4'b0001, 0, 0, 4'd0,  2, 0, 0, 0);

        reset = 1'b1; credito = '0; produto = '0; confirmar = 1'b0;
        cancelar = 1'b0; estoque_vazio = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset liberar_produto", int'(liberar_produto), 0);
        chk("reset produto_liberado", int'(produto_liberado), 0);
        chk("reset troco_moeda", int'(troco_moeda), 0);
        chk("reset zerar_credito", int'(zerar_credito), 0);
        chk("reset ocupado", int'(ocupado), 0);
        chk("reset erro", int'(erro), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) run_vec(i, tab[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
